// File: rtl/mips_pkg.sv
// Shared types for the data-memory arbiter: FSM states, grant owner, and
// the owner loaded into the round-robin pointer on reset.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      DEV_RD = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DEV = 1'b1
   } owner_t;

   // Starting with the device as last owner lets the processor win the first contention.
   localparam owner_t LAST_GNT_RESET = OWN_DEV;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-way round-robin arbiter sharing one synchronous-read data memory
// between the processor data port and a read-only secondary device.
module dmem_arbiter
   import mips_pkg::*;
#(
   parameter int Dbits = 32,
   parameter int Abits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_rd,
   input  logic             cpu_wr,
   input  logic [Abits-1:0] cpu_addr,
   input  logic [Dbits-1:0] cpu_wdata,
   output logic [Dbits-1:0] cpu_rdata,
   output logic             cpu_stall,
   input  logic             dev_req,
   input  logic [Abits-1:0] dev_addr,
   output logic             dev_gnt,
   output logic             dev_rvalid,
   output logic [Dbits-1:0] dev_rdata,
   output logic             m_en,
   output logic             m_wr,
   output logic [Abits-1:0] m_addr,
   output logic [Dbits-1:0] m_wdata,
   input  logic [Dbits-1:0] m_rdata
);

   arb_state_t state_q, state_d;
   owner_t     lastGnt_q, lastGnt_d;

   logic cpuReq;
   logic cpuWin;
   logic devWin;

   // A store wins over a load if both are decoded; either counts as a request.
   assign cpuReq = cpu_rd | cpu_wr;
   assign cpuWin = cpuReq & (~dev_req | (lastGnt_q == OWN_DEV));
   assign devWin = dev_req & ~cpuWin;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         lastGnt_q <= LAST_GNT_RESET;
      end else begin
         state_q   <= state_d;
         lastGnt_q <= lastGnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lastGnt_d = lastGnt_q;
      case (state_q)
         IDLE: begin
            if (cpuWin) begin
               lastGnt_d = OWN_CPU;
               state_d   = cpu_wr ? IDLE : CPU_RD;
            end else if (devWin) begin
               lastGnt_d = OWN_DEV;
               state_d   = DEV_RD;
            end
         end
         // The load still requested during its data cycle is not re-issued.
         CPU_RD:  state_d = IDLE;
         DEV_RD:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cpu_stall looks only at state and cpuReq, never at the processor enable.
   always_comb begin
      m_en       = 1'b0;
      m_wr       = 1'b0;
      m_addr     = cpu_addr;
      m_wdata    = cpu_wdata;
      cpu_rdata  = m_rdata;
      dev_rdata  = m_rdata;
      cpu_stall  = 1'b0;
      dev_gnt    = 1'b0;
      dev_rvalid = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (cpuWin) begin
                  m_en      = 1'b1;
                  m_wr      = cpu_wr;
                  cpu_stall = ~cpu_wr;
               end else if (devWin) begin
                  m_en      = 1'b1;
                  m_addr    = dev_addr;
                  dev_gnt   = 1'b1;
                  cpu_stall = cpuReq;
               end
            end
            CPU_RD: cpu_stall = 1'b0;
            DEV_RD: begin
               dev_rvalid = 1'b1;
               cpu_stall  = cpuReq;
            end
            default: cpu_stall = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous-read memory model;
// expected values are hand-computed per step.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dev_req;
   logic [31:0] dev_addr;
   logic        dev_gnt, dev_rvalid;
   logic [31:0] dev_rdata;
   logic        m_en, m_wr;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata;

   logic [31:0] mem [0:63];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.Dbits(32), .Abits(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dev_req    (dev_req),
      .dev_addr   (dev_addr),
      .dev_gnt    (dev_gnt),
      .dev_rvalid (dev_rvalid),
      .dev_rdata  (dev_rdata),
      .m_en       (m_en),
      .m_wr       (m_wr),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_rdata    (m_rdata)
   );

   // Single-port memory: writes land at the edge, reads appear the cycle after issue.
   always @(posedge clk) begin
      if (m_en) begin
         if (m_wr) mem[m_addr[7:2]] <= m_wdata;
         else      m_rdata <= mem[m_addr[7:2]];
      end
   end

   task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic dreq, input logic [31:0] daddr);
      @(negedge clk);
      reset     = rst;
      cpu_rd    = rd;
      cpu_wr    = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      dev_req   = dreq;
      dev_addr  = daddr;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[8]    = 32'h0000_1234;
      mem[16]   = 32'h0000_CAFE;
      m_rdata   = 32'h0;
      reset     = 1'b1;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      dev_req   = 1'b0;
      dev_addr  = 32'h0;

      // Outputs held quiet under reset even with both requests present.
      applyStimulus(1, 1, 0, 32'h20, 0, 1, 32'h40);
      checkOutput("rst_m_en",   {31'b0, m_en},      0);
      checkOutput("rst_stall",  {31'b0, cpu_stall}, 0);
      checkOutput("rst_devgnt", {31'b0, dev_gnt},   0);

      // Uncontended store completes in the same cycle.
      applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
      checkOutput("st_m_en",  {31'b0, m_en},      1);
      checkOutput("st_m_wr",  {31'b0, m_wr},      1);
      checkOutput("st_addr",  m_addr,             32'h10);
      checkOutput("st_wdata", m_wdata,            32'hDEADBEEF);
      checkOutput("st_stall", {31'b0, cpu_stall}, 0);

      // Read back the stored word.
      applyStimulus(0, 1, 0, 32'h10, 0, 0, 0);
      checkOutput("ldb_stall0", {31'b0, cpu_stall}, 1);
      checkOutput("ldb_m_en0",  {31'b0, m_en},      1);
      checkOutput("ldb_m_wr0",  {31'b0, m_wr},      0);
      applyStimulus(0, 1, 0, 32'h10, 0, 0, 0);
      checkOutput("ldb_stall1", {31'b0, cpu_stall}, 0);
      checkOutput("ldb_m_en1",  {31'b0, m_en},      0);
      checkOutput("ldb_rdata",  cpu_rdata,          32'hDEADBEEF);

      // Uncontended load of 0x20.
      applyStimulus(0, 1, 0, 32'h20, 0, 0, 0);
      checkOutput("ld_stall0", {31'b0, cpu_stall}, 1);
      checkOutput("ld_m_en0",  {31'b0, m_en},      1);
      checkOutput("ld_addr0",  m_addr,             32'h20);
      applyStimulus(0, 1, 0, 32'h20, 0, 0, 0);
      checkOutput("ld_stall1", {31'b0, cpu_stall}, 0);
      checkOutput("ld_m_en1",  {31'b0, m_en},      0);
      checkOutput("ld_rdata",  cpu_rdata,          32'h1234);

      // Device read alone.
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h40);
      checkOutput("dv_gnt0",   {31'b0, dev_gnt},   1);
      checkOutput("dv_m_en0",  {31'b0, m_en},      1);
      checkOutput("dv_addr0",  m_addr,             32'h40);
      checkOutput("dv_stall0", {31'b0, cpu_stall}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h40);
      checkOutput("dv_gnt1",   {31'b0, dev_gnt},    0);
      checkOutput("dv_rvalid", {31'b0, dev_rvalid}, 1);
      checkOutput("dv_rdata",  dev_rdata,           32'hCAFE);
      checkOutput("dv_m_en1",  {31'b0, m_en},       0);

      // Continuous contention after reset: CPU, DEV, CPU, DEV.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         applyStimulus(0, 1, 0, 32'h20, 0, 1, 32'h40);
         checkOutput("ct_cpu_stall", {31'b0, cpu_stall}, 1);
         checkOutput("ct_cpu_gnt",   {31'b0, dev_gnt},   0);
         checkOutput("ct_cpu_addr",  m_addr,             32'h20);
         applyStimulus(0, 1, 0, 32'h20, 0, 1, 32'h40);
         checkOutput("ct_cpd_stall", {31'b0, cpu_stall}, 0);
         checkOutput("ct_cpd_rdata", cpu_rdata,          32'h1234);
         checkOutput("ct_cpd_m_en",  {31'b0, m_en},      0);
         applyStimulus(0, 1, 0, 32'h20, 0, 1, 32'h40);
         checkOutput("ct_dev_gnt",   {31'b0, dev_gnt},   1);
         checkOutput("ct_dev_stall", {31'b0, cpu_stall}, 1);
         checkOutput("ct_dev_addr",  m_addr,             32'h40);
         if (r == 0) begin
            applyStimulus(0, 1, 0, 32'h20, 0, 1, 32'h40);
            checkOutput("ct_dd_rvalid", {31'b0, dev_rvalid}, 1);
            checkOutput("ct_dd_rdata",  dev_rdata,           32'hCAFE);
            checkOutput("ct_dd_stall",  {31'b0, cpu_stall},  1);
            checkOutput("ct_dd_gnt",    {31'b0, dev_gnt},    0);
         end
      end

      // Reset lands while in DEV_RD: the pending read data is dropped.
      applyStimulus(1, 1, 0, 32'h20, 0, 1, 32'h40);
      checkOutput("rd_rvalid", {31'b0, dev_rvalid}, 0);
      checkOutput("rd_stall",  {31'b0, cpu_stall},  0);
      checkOutput("rd_m_en",   {31'b0, m_en},       0);
      applyStimulus(0, 1, 0, 32'h20, 0, 1, 32'h40);
      checkOutput("rd_cpu_first", {31'b0, dev_gnt},   0);
      checkOutput("rd_cpu_stall", {31'b0, cpu_stall}, 1);
      checkOutput("rd_cpu_addr",  m_addr,             32'h20);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("rd_cpd_stall", {31'b0, cpu_stall}, 0);
      checkOutput("rd_cpd_rvld",  {31'b0, dev_rvalid}, 0);

      // One-cycle device pulse that loses to a store is simply withdrawn.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h10, 32'h55AA_0F0F, 1, 32'h40);
      checkOutput("pl_gnt",  {31'b0, dev_gnt}, 0);
      checkOutput("pl_m_wr", {31'b0, m_wr},    1);
      checkOutput("pl_addr", m_addr,           32'h10);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("pl_idle_en1",  {31'b0, m_en},       0);
      checkOutput("pl_idle_gnt1", {31'b0, dev_gnt},    0);
      checkOutput("pl_idle_rv1",  {31'b0, dev_rvalid}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("pl_idle_en2",  {31'b0, m_en},    0);
      checkOutput("pl_idle_gnt2", {31'b0, dev_gnt}, 0);
      applyStimulus(0, 1, 0, 32'h10, 0, 0, 0);
      checkOutput("pl_ld_stall", {31'b0, cpu_stall}, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("pl_ld_rdata", cpu_rdata, 32'h55AA_0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
